// File: rtl/time_keeper.sv
// time_keeper: BCD time-of-day counter (HH:MM:SS) driven by a 0.01 s tick.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous, active-high reset; zeroes time and pulses
//   hundrethSec  one-cycle tick, once per 0.01 s
//   run_en       ticks are counted only while high
//   set_min      pulse: minutes +1 mod 60, clears seconds and hundredths
//   set_hr       pulse: hours +1 mod 24, nothing else changes
//   hr_bcd       hours   {tens[1:0], ones[3:0]}, 00..23
//   min_bcd      minutes {tens[2:0], ones[3:0]}, 00..59
//   sec_bcd      seconds {tens[2:0], ones[3:0]}, 00..59
//   sec_pulse    one cycle, seconds advanced by timekeeping
//   min_pulse    one cycle, minutes advanced by a seconds carry
//   day_wrap     one cycle, 23:59:59 -> 00:00:00 by timekeeping
module time_keeper #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hundrethSec,
  input  logic       run_en,
  input  logic       set_min,
  input  logic       set_hr,
  output logic [5:0] hr_bcd,
  output logic [6:0] min_bcd,
  output logic [6:0] sec_bcd,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       day_wrap
);

  localparam logic [6:0] HUND_MAX = 7'(TICKS_PER_SEC - 1);

  logic [6:0] hund_cnt;
  logic       set_any;
  logic       tick;
  logic       sec_carry;
  logic       min_carry;
  logic       hr_carry;

  // BCD increment 00..59 with wrap; digits always stay legal.
  function automatic logic [6:0] inc_60(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[6:4] = (v[6:4] >= 3'd5) ? 3'd0 : v[6:4] + 3'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[6:4] = v[6:4];
    end
    return r;
  endfunction

  // BCD increment 00..23 with wrap.
  function automatic logic [5:0] inc_24(input logic [5:0] v);
    logic [5:0] r;
    if (v == 6'h23) begin
      r = 6'h00;
    end else if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[5:4] = v[5:4] + 2'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[5:4] = v[5:4];
    end
    return r;
  endfunction

  // Set pulses win over a coincident tick; the tick is simply lost.
  always_comb begin
    set_any   = set_min | set_hr;
    tick      = hundrethSec & run_en & ~set_any;
    sec_carry = tick & (hund_cnt == HUND_MAX);
    min_carry = sec_carry & (sec_bcd == 7'h59);
    hr_carry  = min_carry & (min_bcd == 7'h59);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hund_cnt  <= '0;
      sec_bcd   <= '0;
      min_bcd   <= '0;
      hr_bcd    <= '0;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      sec_pulse <= sec_carry;
      min_pulse <= min_carry;
      day_wrap  <= hr_carry & (hr_bcd == 6'h23);

      if (set_any) begin
        if (set_min) begin
          hund_cnt <= '0;
          sec_bcd  <= '0;
          min_bcd  <= inc_60(min_bcd);
        end
        if (set_hr) begin
          hr_bcd <= inc_24(hr_bcd);
        end
      end else if (tick) begin
        if (sec_carry) begin
          hund_cnt <= '0;
          sec_bcd  <= inc_60(sec_bcd);
        end else begin
          hund_cnt <= hund_cnt + 7'd1;
        end
        if (min_carry) begin
          min_bcd <= inc_60(min_bcd);
        end
        if (hr_carry) begin
          hr_bcd <= inc_24(hr_bcd);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a short per-cycle vector table followed by
// hand-written multi-cycle sequences for carries, set mode and reset corners.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hundrethSec = 1'b0;
  logic       run_en = 1'b0;
  logic       set_min = 1'b0;
  logic       set_hr = 1'b0;
  logic [5:0] hr_bcd;
  logic [6:0] min_bcd;
  logic [6:0] sec_bcd;
  logic       sec_pulse;
  logic       min_pulse;
  logic       day_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int sp_cnt, mp_cnt, dw_cnt;

  time_keeper #(.TICKS_PER_SEC(100)) dut (
    .clk(clk), .rst(rst), .hundrethSec(hundrethSec), .run_en(run_en),
    .set_min(set_min), .set_hr(set_hr), .hr_bcd(hr_bcd), .min_bcd(min_bcd),
    .sec_bcd(sec_bcd), .sec_pulse(sec_pulse), .min_pulse(min_pulse),
    .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, hs, run, smin, shr;
    logic [5:0] hr;
    logic [6:0] mn, sc;
    logic       sp, mp, dw;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic r, input logic hs, input logic run,
                              input logic smin, input logic shr,
                              input logic [5:0] hr, input logic [6:0] mn,
                              input logic [6:0] sc, input logic sp,
                              input logic mp, input logic dw);
    vec_t v;
    v.rst = r; v.hs = hs; v.run = run; v.smin = smin; v.shr = shr;
    v.hr = hr; v.mn = mn; v.sc = sc; v.sp = sp; v.mp = mp; v.dw = dw;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input logic [5:0] h,
                          input logic [6:0] m, input logic [6:0] s);
    chk({name, " hr"}, int'(hr_bcd), int'(h));
    chk({name, " min"}, int'(min_bcd), int'(m));
    chk({name, " sec"}, int'(sec_bcd), int'(s));
  endtask

  task automatic chk_pulses(input string name, input logic sp, input logic mp,
                            input logic dw);
    chk({name, " sec_pulse"}, int'(sec_pulse), int'(sp));
    chk({name, " min_pulse"}, int'(min_pulse), int'(mp));
    chk({name, " day_wrap"}, int'(day_wrap), int'(dw));
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 ns later and
  // accumulate any pulses seen.
  task automatic cyc(input logic r, input logic hs, input logic run,
                     input logic smin, input logic shr);
    rst = r; hundrethSec = hs; run_en = run; set_min = smin; set_hr = shr;
    @(posedge clk);
    #1;
    sp_cnt += int'(sec_pulse);
    mp_cnt += int'(min_pulse);
    dw_cnt += int'(day_wrap);
  endtask

  task automatic clr_cnt();
    sp_cnt = 0; mp_cnt = 0; dw_cnt = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic press_hr(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clr_cnt();
    vecs[0] = mk(1, 0, 0, 0, 0, 6'h00, 7'h00, 7'h00, 0, 0, 0);
    vecs[1] = mk(0, 0, 1, 0, 1, 6'h01, 7'h00, 7'h00, 0, 0, 0);
    vecs[2] = mk(0, 0, 1, 1, 0, 6'h01, 7'h01, 7'h00, 0, 0, 0);
    vecs[3] = mk(0, 0, 1, 1, 1, 6'h02, 7'h02, 7'h00, 0, 0, 0);
    vecs[4] = mk(0, 1, 1, 0, 1, 6'h03, 7'h02, 7'h00, 0, 0, 0);
    vecs[5] = mk(0, 1, 0, 0, 0, 6'h03, 7'h02, 7'h00, 0, 0, 0);
    vecs[6] = mk(1, 1, 1, 0, 1, 6'h00, 7'h00, 7'h00, 0, 0, 0);
    vecs[7] = mk(0, 1, 1, 0, 0, 6'h00, 7'h00, 7'h00, 0, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].rst, vecs[i].hs, vecs[i].run, vecs[i].smin, vecs[i].shr);
      chk_time($sformatf("vec%0d", i), vecs[i].hr, vecs[i].mn, vecs[i].sc);
      chk_pulses($sformatf("vec%0d", i), vecs[i].sp, vecs[i].mp, vecs[i].dw);
    end

    // First second after reset: sec_pulse lands the cycle after tick 100.
    do_reset();
    clr_cnt();
    ticks(99);
    chk_time("99 ticks", 6'h00, 7'h00, 7'h00);
    chk("99 ticks sp_cnt", sp_cnt, 0);
    ticks(1);
    chk_time("100 ticks", 6'h00, 7'h00, 7'h01);
    chk_pulses("100 ticks", 1'b1, 1'b0, 1'b0);
    idle();
    chk_pulses("after 1s", 1'b0, 1'b0, 1'b0);
    chk("1s sp_cnt", sp_cnt, 1);

    // Day wrap from 23:59:59.
    do_reset();
    clr_cnt();
    press_hr(23);
    press_min(59);
    chk_time("preload 23:59", 6'h23, 7'h59, 7'h00);
    chk("set mp_cnt", mp_cnt, 0);
    chk("set dw_cnt", dw_cnt, 0);
    ticks(5900);
    chk_time("23:59:59", 6'h23, 7'h59, 7'h59);
    chk("59s sp_cnt", sp_cnt, 59);
    ticks(99);
    chk_time("23:59:59.99", 6'h23, 7'h59, 7'h59);
    ticks(1);
    chk_time("day wrap", 6'h00, 7'h00, 7'h00);
    chk_pulses("day wrap", 1'b1, 1'b1, 1'b1);
    idle();
    chk_pulses("after wrap", 1'b0, 1'b0, 1'b0);

    // set_min from 12:34:56.xx clears seconds and hundredths.
    do_reset();
    press_hr(12);
    press_min(34);
    ticks(5637);
    chk_time("12:34:56", 6'h12, 7'h34, 7'h56);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_time("set_min 12:35", 6'h12, 7'h35, 7'h00);
    chk_pulses("set_min 12:35", 1'b0, 1'b0, 1'b0);
    ticks(99);
    chk_time("hund cleared 99", 6'h12, 7'h35, 7'h00);
    ticks(1);
    chk_time("hund cleared 100", 6'h12, 7'h35, 7'h01);
    press_min(24);
    chk_time("min 59", 6'h12, 7'h59, 7'h00);
    clr_cnt();
    press_min(1);
    chk_time("min wrap", 6'h12, 7'h00, 7'h00);
    chk("min wrap mp_cnt", mp_cnt, 0);

    // set_hr at 23 wraps to 00 without day_wrap; min/sec untouched.
    press_hr(11);
    press_min(7);
    ticks(250);
    chk_time("23:07:02", 6'h23, 7'h07, 7'h02);
    clr_cnt();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_time("hr wrap", 6'h00, 7'h07, 7'h02);
    chk("hr wrap dw_cnt", dw_cnt, 0);

    // Tick coincident with set_min at hundredths=99 is discarded.
    do_reset();
    ticks(399);
    chk_time("00:00:03.99", 6'h00, 7'h00, 7'h03);
    clr_cnt();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_time("tick+set_min", 6'h00, 7'h01, 7'h00);
    chk("tick+set_min sp_cnt", sp_cnt, 0);
    ticks(1);
    chk_time("tick after set_min", 6'h00, 7'h01, 7'h00);
    chk("tick after set_min sp_cnt", sp_cnt, 0);

    // run_en low freezes time.
    clr_cnt();
    for (int i = 0; i < 500; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_time("run_en=0", 6'h00, 7'h01, 7'h00);
    chk("run_en=0 sp_cnt", sp_cnt, 0);
    ticks(100);
    chk_time("run_en=0 resumed", 6'h00, 7'h01, 7'h01);

    // Reset in the cycle of the 00:00:59.99 tick beats the carry.
    do_reset();
    ticks(5999);
    chk_time("00:00:59.99", 6'h00, 7'h00, 7'h59);
    clr_cnt();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_time("rst mid-carry", 6'h00, 7'h00, 7'h00);
    chk_pulses("rst mid-carry", 1'b0, 1'b0, 1'b0);
    idle();
    chk_pulses("after rst", 1'b0, 1'b0, 1'b0);
    ticks(100);
    chk_time("resume after rst", 6'h00, 7'h00, 7'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
